// File: rtl/token_move_scheduler.sv
// Race-board token sequencer: takes a legal dice roll, hops the active player's
// token one tile per STEP_CYCLES, clamps at the finish tile, alternates turns, latches the winner.
module token_move_scheduler #(
    parameter int          STEP_CYCLES = 12_500_000,
    parameter logic [3:0]  LAST_TILE   = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_reset,
    input  logic       start,
    input  logic [2:0] dice_value,
    output logic       busy,
    output logic       done,
    output logic       cur_player,
    output logic [3:0] p0_tile,
    output logic [3:0] p1_tile,
    output logic [3:0] anim_tile_idx,
    output logic       winner_valid,
    output logic       winner
);

    localparam logic [23:0] STEP_LAST = 24'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DONE = 2'd2,
        WIN  = 2'd3
    } state_t;

    state_t      state_q;
    logic [23:0] timer_q;
    logic [2:0]  steps_q;
    logic [3:0]  p0_q;
    logic [3:0]  p1_q;
    logic        cur_q;
    logic        busy_q;
    logic        done_q;
    logic        wv_q;
    logic        win_q;

    logic [3:0]  active_tile_d;
    logic [3:0]  next_tile_d;
    logic        dice_ok_d;
    logic        at_finish_d;

    always_comb begin
        active_tile_d = cur_q ? p1_q : p0_q;
        next_tile_d   = active_tile_d + 4'd1;
        at_finish_d   = (active_tile_d == LAST_TILE);
        dice_ok_d     = (dice_value != 3'd0) && (dice_value != 3'd7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= 24'd0;
            steps_q <= 3'd0;
            p0_q    <= 4'd0;
            p1_q    <= 4'd0;
            cur_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wv_q    <= 1'b0;
            win_q   <= 1'b0;
        end else if (game_reset) begin
            state_q <= IDLE;
            timer_q <= 24'd0;
            steps_q <= 3'd0;
            p0_q    <= 4'd0;
            p1_q    <= 4'd0;
            cur_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wv_q    <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && dice_ok_d) begin
                        steps_q <= dice_value;
                        timer_q <= 24'd0;
                        busy_q  <= 1'b1;
                        state_q <= MOVE;
                    end
                end
                MOVE: begin
                    // Reaching the finish discards leftover steps, which is the overshoot clamp.
                    if (steps_q == 3'd0 || at_finish_d) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (timer_q == STEP_LAST) begin
                        if (cur_q) p1_q <= next_tile_d;
                        else       p0_q <= next_tile_d;
                        steps_q <= steps_q - 3'd1;
                        timer_q <= 24'd0;
                    end else begin
                        timer_q <= timer_q + 24'd1;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    if (at_finish_d) begin
                        wv_q    <= 1'b1;
                        win_q   <= cur_q;
                        state_q <= WIN;
                    end else begin
                        cur_q   <= ~cur_q;
                        state_q <= IDLE;
                    end
                end
                WIN: begin
                    state_q <= WIN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign cur_player    = cur_q;
    assign p0_tile       = p0_q;
    assign p1_tile       = p1_q;
    assign anim_tile_idx = active_tile_d;
    assign winner_valid  = wv_q;
    assign winner        = win_q;

endmodule

// File: tb/tb_token_move_scheduler.sv
// Randomized bench for token_move_scheduler, checked cycle by cycle against a
// positional model of the game rules (tile = start + hops elapsed, clamped).
module tb_token_move_scheduler;

    localparam int S  = 4;
    localparam int LT = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] dice_value = 3'd0;
    logic       busy, done, cur_player, winner_valid, winner;
    logic [3:0] p0_tile, p1_tile, anim_tile_idx;

    token_move_scheduler #(.STEP_CYCLES(S), .LAST_TILE(4'(LT))) dut (
        .clk(clk), .rst_n(rst_n), .game_reset(game_reset), .start(start),
        .dice_value(dice_value), .busy(busy), .done(done), .cur_player(cur_player),
        .p0_tile(p0_tile), .p1_tile(p1_tile), .anim_tile_idx(anim_tile_idx),
        .winner_valid(winner_valid), .winner(winner)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int m_tile[2];
    int m_cur, m_wv, m_win;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        m_tile[0] = 0; m_tile[1] = 0; m_cur = 0; m_wv = 0; m_win = 0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".cur"}, 32'(cur_player), 32'(m_cur));
        chk({tag, ".p0"}, 32'(p0_tile), 32'(m_tile[0]));
        chk({tag, ".p1"}, 32'(p1_tile), 32'(m_tile[1]));
        chk({tag, ".anim"}, 32'(anim_tile_idx), 32'(m_tile[m_cur]));
        chk({tag, ".wv"}, 32'(winner_valid), 32'(m_wv));
        chk({tag, ".win"}, 32'(winner), 32'(m_win));
    endtask

    // rst_at > 0 asserts game_reset so that it is sampled at edge E0+rst_at.
    task automatic do_move(input int dice, input int rst_at);
        int a, st, n, exp_tile;
        bit legal;
        legal = (dice >= 1) && (dice <= 6) && (m_wv == 0);
        dice_value = 3'(dice);
        start = 1'b1;
        step();
        start = 1'b0;
        if (!legal) begin
            chk_idle("ignored");
            return;
        end
        a  = m_cur;
        st = m_tile[a];
        n  = (dice < LT - st) ? dice : LT - st;
        for (int t = 0; t <= n * S + 1; t++) begin
            if (t > 0) begin
                if (t == rst_at) begin
                    game_reset = 1'b1;
                    start = 1'b1;
                    dice_value = 3'd2;
                    step();
                    game_reset = 1'b0;
                    start = 1'b0;
                    model_zero();
                    chk_idle("greset");
                    step();
                    chk_idle("greset_hold");
                    return;
                end
                start = ($urandom_range(0, 3) == 0);
                dice_value = 3'($urandom_range(1, 6));
                step();
                start = 1'b0;
            end
            exp_tile = st + (((t / S) < n) ? (t / S) : n);
            chk("mv.busy", 32'(busy), 1);
            chk("mv.done", 32'(done), 32'(t == n * S + 1));
            chk("mv.cur", 32'(cur_player), 32'(a));
            chk("mv.active", 32'(a ? p1_tile : p0_tile), 32'(exp_tile));
            chk("mv.other", 32'(a ? p0_tile : p1_tile), 32'(m_tile[1 - a]));
            chk("mv.anim", 32'(anim_tile_idx), 32'(exp_tile));
            chk("mv.wv", 32'(winner_valid), 32'(m_wv));
        end
        step();
        m_tile[a] = st + n;
        if (m_tile[a] == LT) begin
            m_wv = 1;
            m_win = a;
        end else begin
            m_cur = 1 - a;
        end
        chk_idle("end");
    endtask

    task automatic pulse_game_reset();
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
        model_zero();
        chk_idle("greset_pulse");
    endtask

    initial begin
        model_zero();
        step();
        step();
        rst_n = 1'b1;
        chk_idle("reset");

        // Basic move, then alternation.
        do_move(3, -1);
        do_move(2, -1);
        pulse_game_reset();
        do_move(5, -1);
        do_move(2, -1);

        // Illegal dice in IDLE.
        do_move(0, -1);
        do_move(7, -1);

        // game_reset in the middle of a dice=4 move.
        do_move(4, 6);

        // Overshoot clamp and win, start ignored in WIN, restart.
        do_move(6, -1);
        do_move(1, -1);
        do_move(1, -1);
        do_move(1, -1);
        do_move(6, -1);
        chk("win.wv", 32'(winner_valid), 1);
        chk("win.who", 32'(winner), 0);
        do_move(3, -1);
        pulse_game_reset();
        do_move(1, -1);

        // Asynchronous reset in the middle of a hop.
        dice_value = 3'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        model_zero();
        chk_idle("async_rst");
        step();
        rst_n = 1'b1;
        chk_idle("async_rst_rel");

        for (int i = 0; i < 60; i++) begin
            if (m_wv != 0) begin
                do_move($urandom_range(1, 6), -1);
                pulse_game_reset();
            end else if ($urandom_range(0, 9) == 0) begin
                do_move($urandom_range(1, 6), $urandom_range(1, S));
            end else begin
                do_move($urandom_range(0, 7), -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
